// File: rtl/key_led_pkg.sv
// rtl/key_led_pkg.sv - shared mode encoding, LED constants and counter sizing for key_led_ctrl
package key_led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_t;

  localparam logic [3:0] LED_RUN_INIT = 4'b0001;
  localparam logic [3:0] LED_ALL_ON   = 4'hF;
  localparam logic [3:0] LED_ALL_OFF  = 4'h0;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-flop synchroniser, debounce counter, one-cycle press pulse
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_db,
  output logic key_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          key_s;
  logic          key_db_d;
  logic [CW-1:0] cnt;

  // Raw key is active-low; key_s is 1 while pressed.
  assign key_s = ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      key_db    <= 1'b0;
      key_db_d  <= 1'b0;
      key_press <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1     <= key;
      sync2     <= sync1;
      key_db_d  <= key_db;
      key_press <= key_db & ~key_db_d;
      if (key_s == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_db <= key_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - key-driven LED pattern controller (mode FSM, step timer, LED register)
// Optional 25% dimming when KEY_LED_CTRL_DIM_EN is defined.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int STEP_CYC     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic [3:0] led,
  output logic [1:0] mode
);

  localparam int SW = cnt_width(STEP_CYC);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYC - 1);

  logic [3:0]    key_db;
  logic [3:0]    key_press;
  logic          press_any;
  logic          step_tick;
  logic [SW-1:0] step_cnt;
  mode_t         state;
  mode_t         state_next;
  logic [3:0]    pattern;
  logic [3:0]    pattern_next;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
      .clk      (clk),
      .rst_n    (rst_n),
      .key      (key[i]),
      .key_db   (key_db[i]),
      .key_press(key_press[i])
    );
  end

  assign press_any = |key_press;
  assign step_tick = (step_cnt == STEP_MAX);

  // Lowest-index press wins; a press always re-enters its mode so the pattern restarts.
  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    if (key_press[0])      state_next = MODE_RUN;
    else if (key_press[1]) state_next = MODE_BLINK;
    else if (key_press[2]) state_next = MODE_STATIC;
    else if (key_press[3]) state_next = MODE_OFF;

    if (press_any) begin
      case (state_next)
        MODE_STATIC: pattern_next = key_db;
        MODE_RUN:    pattern_next = LED_RUN_INIT;
        MODE_BLINK:  pattern_next = LED_ALL_ON;
        MODE_OFF:    pattern_next = LED_ALL_OFF;
        default:     pattern_next = LED_ALL_OFF;
      endcase
    end else begin
      case (state)
        MODE_STATIC: pattern_next = key_db;
        MODE_RUN:    if (step_tick) pattern_next = {pattern[2:0], pattern[3]};
        MODE_BLINK:  if (step_tick) pattern_next = ~pattern;
        MODE_OFF:    pattern_next = LED_ALL_OFF;
        default:     pattern_next = LED_ALL_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MODE_STATIC;
      pattern  <= LED_ALL_OFF;
      step_cnt <= '0;
    end else begin
      state   <= state_next;
      pattern <= pattern_next;
      if (press_any || step_tick) step_cnt <= '0;
      else                        step_cnt <= step_cnt + SW'(1);
    end
  end

  assign mode = state;

`ifdef KEY_LED_CTRL_DIM_EN
  logic [1:0] pwm;
  logic [3:0] led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm   <= 2'd0;
      led_q <= LED_ALL_OFF;
    end else begin
      pwm   <= pwm + 2'd1;
      led_q <= pattern_next & {4{pwm == 2'd0}};
    end
  end

  assign led = led_q;
`else
  assign led = pattern;
`endif

endmodule

// File: tb/tb_key_led_ctrl.sv
// tb/tb_key_led_ctrl.sv - directed scoreboard bench for key_led_ctrl (DEBOUNCE_CYC=4, STEP_CYC=8)
module tb_key_led_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] led;
  logic [1:0] mode;

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic [3:0] led;
    bit         chk_led;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  key_led_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .STEP_CYC    (STEP)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key),
    .led  (led),
    .mode (mode)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [1:0] m, input logic [3:0] l, input bit cl);
    exp_t e;
    e.tag     = tag;
    e.mode    = m;
    e.led     = l;
    e.chk_led = cl;
`ifdef KEY_LED_CTRL_DIM_EN
    e.chk_led = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed mode=%0d led=%b, required a queued expectation", mode, led);
      return;
    end
    e = sb.pop_front();
    assert (mode === e.mode && (!e.chk_led || led === e.led)) else begin
      n_err++;
      $error("FAIL %s: observed mode=%0d led=%b, required mode=%0d led=%b%s",
             e.tag, mode, led, e.mode, e.led, e.chk_led ? "" : " (led not checked)");
    end
  endtask

  initial begin
    // Reset with keys released
    step(3);
    push("reset_state", 2'd0, 4'h0, 1);
    check();
    rst_n = 1'b1;
    push("after_release", 2'd0, 4'h0, 1);
    step(1);
    check();

    // Key 0 held for only 3 cycles: below the debounce threshold
    key = 4'hE;
    push("short_press_ignored", 2'd0, 4'h0, 1);
    step(3);
    key = 4'hF;
    step(10);
    check();

    // Key 0 with one glitch cycle, then held: one press, RUN
    key = 4'hE;
    push("run_not_yet", 2'd0, 4'b0001, 1);
    push("run_entry",   2'd1, 4'b0001, 1);
    push("run_hold",    2'd1, 4'b0001, 1);
    push("run_step1",   2'd1, 4'b0010, 1);
    push("run_step3",   2'd1, 4'b1000, 1);
    push("run_wrap",    2'd1, 4'b0001, 1);
    step(2);
    key = 4'hF;
    step(1);
    key = 4'hE;
    step(7);  check();
    step(1);  check();
    step(7);  check();
    step(1);  check();
    step(16); check();
    step(8);  check();
    key = 4'hF;
    step(10);

    // RUN -> BLINK
    key = 4'hD;
    push("blink_pending", 2'd1, 4'h0, 0);
    push("blink_entry",   2'd2, 4'hF, 1);
    push("blink_hold",    2'd2, 4'hF, 1);
    push("blink_off",     2'd2, 4'h0, 1);
    push("blink_on",      2'd2, 4'hF, 1);
    step(7); check();
    step(1); check();
    step(7); check();
    step(1); check();
    step(8); check();
    key = 4'hF;
    step(10);

    // Keys 0 and 3 together: key 0 wins
    key = 4'h6;
    push("dual_pending", 2'd2, 4'h0, 0);
    push("dual_run",     2'd1, 4'b0001, 1);
    push("dual_hold",    2'd1, 4'b0001, 1);
    step(7); check();
    step(1); check();
    step(1); check();
    key = 4'hF;
    step(10);

    // STATIC mirrors debounced keys
    key = 4'hB;
    push("static_pending", 2'd1, 4'h0, 0);
    push("static_entry",   2'd0, 4'b0100, 1);
    step(7); check();
    step(1); check();
    key = 4'hF;
    push("static_release", 2'd0, 4'h0, 1);
    step(10); check();
    key = 4'h5;
    push("mirror_pending",     2'd0, 4'h0, 1);
    push("mirror",             2'd0, 4'b1010, 1);
    push("mirror_press_blink", 2'd2, 4'hF, 1);
    step(6); check();
    step(1); check();
    step(1); check();

    // Asynchronous reset mid-step, keys still held
    step(3);
    rst_n = 1'b0;
    #1;
    push("reset_mid", 2'd0, 4'h0, 1);
    check();
    step(2);
    rst_n = 1'b1;
    push("rearm_static", 2'd0, 4'b1010, 1);
    push("rearm_blink",  2'd2, 4'hF, 1);
    step(7); check();
    step(1); check();

    // BLINK -> OFF
    key = 4'hF;
    step(10);
    key = 4'h7;
    push("off_pending", 2'd2, 4'h0, 0);
    push("off_entry",   2'd3, 4'h0, 1);
    push("off_hold",    2'd3, 4'h0, 1);
    step(7); check();
    step(1); check();
    step(9); check();

`ifdef KEY_LED_CTRL_DIM_EN
    // Reach STATIC with every key pressed, then measure duty
    begin
      int n_on;
      int n_off;
      n_on  = 0;
      n_off = 0;
      key = 4'h0;
      step(12);
      key = 4'h4;
      step(12);
      key = 4'h0;
      push("dim_static", 2'd0, 4'h0, 0);
      step(10); check();
      for (int i = 0; i < 16; i++) begin
        step(1);
        if (led === 4'hF) n_on++;
        else if (led === 4'h0) n_off++;
      end
      n_vec++;
      assert (n_on == 4 && n_off == 12) else begin
        n_err++;
        $error("FAIL dim_duty: observed on=%0d off=%0d, required on=4 off=12", n_on, n_off);
      end
    end
`endif

    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d pending, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
